// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch-to-decode instruction queue (optional same-cycle bypass via IF_ID_QUEUE_BYPASS_EN)
`ifndef WORD_ADDR_BUS
`define WORD_ADDR_BUS 31:0
`endif
`ifndef DATA_WIDTH_INSN
`define DATA_WIDTH_INSN 31:0
`endif

module if_id_queue #(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpu_en,
  input  logic                        if_en,
  input  logic [`WORD_ADDR_BUS]       if_pc,
  input  logic [`DATA_WIDTH_INSN]     if_insn,
  output logic                        if_ready,
  input  logic                        br_taken,
  input  logic                        id_ready,
  output logic                        id_en,
  output logic [`WORD_ADDR_BUS]       id_pc,
  output logic [`DATA_WIDTH_INSN]     id_insn,
  output logic [$clog2(DEPTH):0]      q_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [`WORD_ADDR_BUS]   pc_mem   [DEPTH];
  logic [`DATA_WIDTH_INSN] insn_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic empty, full, push_req, push, pop, byp;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign if_ready = cpu_en && !full;
  assign push_req = if_en && if_ready && !br_taken;

`ifdef IF_ID_QUEUE_BYPASS_EN
  // Empty queue forwards the fetch straight to decode; it is only stored if decode stalls.
  assign byp = empty && push_req;
`else
  assign byp = 1'b0;
`endif

  assign push  = push_req && !(byp && id_ready);
  assign pop   = cpu_en && !br_taken && !empty && id_ready;
  assign id_en = cpu_en && !br_taken && (!empty || byp);

  always_comb begin
    id_pc   = '0;
    id_insn = '0;
    if (id_en) begin
      if (byp) begin
        id_pc   = if_pc;
        id_insn = if_insn;
      end else begin
        id_pc   = pc_mem[rd_ptr_q];
        id_insn = insn_mem[rd_ptr_q];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (cpu_en) begin
      if (br_taken) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
      end else begin
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   cnt_d = cnt_q + 1'b1;
          2'b01:   cnt_d = cnt_q - 1'b1;
          default: cnt_d = cnt_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; push already excludes flush and stalled cycles.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[wr_ptr_q]   <= if_pc;
      insn_mem[wr_ptr_q] <= if_insn;
    end
  end

  assign q_cnt = cnt_q;

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning queue entries; legal values are powers of two, 2 to 8.
REQ-002 The block SHALL have port clk  input  1  the single clock, rising-edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset (one clock, synchronous, active-high).
REQ-004 The block SHALL have port cpu_en  input  1  global run enable.
REQ-005 The block SHALL have port if_en  input  1  fetch-side valid.
REQ-006 The block SHALL have port if_pc  input  `WORD_ADDR_BUS  fetched PC.
REQ-007 The block SHALL have port if_insn  input  `DATA_WIDTH_INSN  fetched instruction.
REQ-008 The block SHALL have port if_ready  output  1  queue can accept a fetch this cycle.
REQ-009 The block SHALL have port br_taken  input  1  flush request from branch resolution.
REQ-010 The block SHALL have port id_ready  input  1  decode accepts the head entry this cycle.
REQ-011 The block SHALL have port id_en  output  1  head entry valid toward decode.
REQ-012 The block SHALL have port id_pc  output  `WORD_ADDR_BUS  head PC.
REQ-013 The block SHALL have port id_insn  output  `DATA_WIDTH_INSN  head instruction.
REQ-014 The block SHALL have port q_cnt  output  log2(DEPTH)+1  current occupancy.

Function
REQ-015 The block SHALL implement a circular FIFO: write pointer, read pointer, and count; pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 The block SHALL drive if_ready = cpu_en && (q_cnt < DEPTH); if_ready SHALL be 0 while full.
REQ-017 The block SHALL push on (if_en && if_ready && !br_taken), storing {if_pc, if_insn} at the write pointer.
REQ-018 The block SHALL drive id_en = cpu_en && (q_cnt != 0) && !br_taken, with id_pc/id_insn taken from the read-pointer entry.
REQ-019 The block SHALL pop on (id_en && id_ready).
REQ-020 On a simultaneous push and pop, q_cnt SHALL be unchanged and both pointers SHALL advance.
REQ-021 On br_taken=1, the block SHALL clear q_cnt and both pointers at the next edge, discard any push that cycle, and perform no pop.
REQ-022 While cpu_en=0, the block SHALL hold all state; if_ready=0 and id_en=0.
REQ-023 id_pc and id_insn SHALL be 0 whenever id_en=0.
REQ-024 Minimum fetch-to-decode latency SHALL be 1 cycle; the head entry SHALL stay stable until popped or flushed.
REQ-025 Stored order SHALL be preserved; no entry SHALL be duplicated or skipped across wrap-around.

Reset
REQ-026 When reset=1 at a rising edge, the block SHALL set q_cnt, write pointer and read pointer to 0; storage contents are don't-care.
REQ-027 During and after reset, until the first push, the block SHALL hold if_ready=cpu_en, id_en=0, id_pc=0, id_insn=0.
REQ-028 Reset SHALL take priority over br_taken, push and pop.

Configuration
REQ-029 The block SHALL support the macro IF_ID_QUEUE_BYPASS_EN.
REQ-030 With IF_ID_QUEUE_BYPASS_EN defined and q_cnt=0, cpu_en=1, br_taken=0, if_en=1: the block SHALL present if_pc/if_insn on id_*, drive id_en=1 in the same cycle, and write the entry only if id_ready=0; latency is 0 cycles.
REQ-031 Without IF_ID_QUEUE_BYPASS_EN, the block SHALL provide no combinational path from if_* to id_*, and latency SHALL be exactly as in REQ-024.

Verification
REQ-032 Bench SHALL cover: reset, then push pc=0x00,0x04 with id_ready=0 -> q_cnt=2, if_ready=0, id_pc=0x00.
REQ-033 Bench SHALL cover: full queue, id_ready=1 for 2 cycles, if_en=0 -> id_pc 0x00 then 0x04, q_cnt 2->1->0, id_en=0 after.
REQ-034 Bench SHALL cover: q_cnt=1, push 0x08 and pop same cycle -> q_cnt stays 1, next head pc=0x08.
REQ-035 Bench SHALL cover: q_cnt=2, br_taken=1 with if_en=1 -> id_en=0 that cycle, q_cnt=0 next cycle, flushed PCs never reappear.
REQ-036 Bench SHALL cover: stream of 10 instructions pc 0x00..0x24 with random id_ready -> output order exact across pointer wrap.
REQ-037 Bench SHALL cover: bypass build, empty queue, if_en=1, if_pc=0x40, id_ready=1 -> id_en=1, id_pc=0x40 same cycle, q_cnt remains 0.
